// File: rtl/ldpc_ber_pkg.sv
// Shared types and widths for the LDPC BER sweep controller.
package ldpc_ber_pkg;

    localparam int unsigned CNT_W    = 64;
    localparam int unsigned FACTOR_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StRun,
        StDrain,
        StReport
    } sweep_state_e;

endpackage

// File: rtl/ldpc_sat_step.sv
// Unsigned factor plus signed step, clamped to the unsigned factor range.
module ldpc_sat_step
    import ldpc_ber_pkg::*;
(
    input  logic [FACTOR_W-1:0] base_i,
    input  logic [FACTOR_W-1:0] step_i,
    output logic [FACTOR_W-1:0] result_o
);

    // Two guard bits: one for the carry above 0xFFFF, one for the sign below zero.
    logic signed [FACTOR_W+1:0] sum;

    assign sum = $signed({2'b00, base_i}) + $signed({{2{step_i[FACTOR_W-1]}}, step_i});

    always_comb begin
        result_o = sum[FACTOR_W-1:0];
        if (sum[FACTOR_W+1]) begin
            result_o = '0;
        end else if (sum[FACTOR_W]) begin
            result_o = '1;
        end
    end

endmodule

// File: rtl/ldpc_ber_sweep_ctrl.sv
// SNR sweep sequencer: steps the AWGN factor, runs each point to its budget,
// drains the datapath and hands one result record per point to the consumer.
module ldpc_ber_sweep_ctrl
    import ldpc_ber_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 16,
    parameter int unsigned POINT_W      = 8
) (
    input  logic                data_clk,
    input  logic                data_reset,
    input  logic                ctrl_start,
    input  logic                ctrl_abort,
    input  logic [FACTOR_W-1:0] cfg_factor_start,
    input  logic [FACTOR_W-1:0] cfg_factor_step,
    input  logic [POINT_W-1:0]  cfg_num_points,
    input  logic [CNT_W-1:0]    cfg_max_blocks,
    input  logic [CNT_W-1:0]    cfg_min_failed,
    input  logic [CNT_W-1:0]    data_finished_blocks,
    input  logic [CNT_W-1:0]    data_bit_errors,
    input  logic [CNT_W-1:0]    data_failed_blocks,
    input  logic [31:0]         data_in_flight,
    output logic                data_en,
    output logic                data_sw_resetn,
    output logic [FACTOR_W-1:0] data_factor,
    output logic                status_busy,
    output logic                status_done,
    output logic [POINT_W-1:0]  status_point,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [POINT_W-1:0]  res_point,
    output logic [FACTOR_W-1:0] res_factor,
    output logic [CNT_W-1:0]    res_finished,
    output logic [CNT_W-1:0]    res_bit_errors,
    output logic [CNT_W-1:0]    res_failed
);

    localparam int unsigned    RstW    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [RstW-1:0] RstLast = RstW'(RESET_CYCLES - 1);

    sweep_state_e         state_q, state_d;
    logic [RstW-1:0]      rst_cnt_q, rst_cnt_d;
    logic [POINT_W-1:0]   point_q, point_d, num_points_q;
    logic [FACTOR_W-1:0]  factor_q, factor_d, step_q, factor_next;
    logic [CNT_W-1:0]     max_blocks_q, min_failed_q;
    logic                 abort_q, abort_d, done_q, done_d, drain_seen_q;
    logic                 start_ok, stop, last_point, capture;

    ldpc_sat_step u_sat_step (
        .base_i   (factor_q),
        .step_i   (step_q),
        .result_o (factor_next)
    );

    // Abort has priority over a simultaneous start.
    assign start_ok   = ctrl_start & ~ctrl_abort;
    assign last_point = (point_q == num_points_q - POINT_W'(1));
    assign stop       = ((max_blocks_q != '0) && (data_finished_blocks >= max_blocks_q)) ||
                        ((min_failed_q != '0) && (data_failed_blocks >= min_failed_q));

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = '0;
        point_d   = point_q;
        factor_d  = factor_q;
        abort_d   = (state_q == StIdle) ? 1'b0 : (abort_q | ctrl_abort);
        done_d    = done_q;
        capture   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_ok) begin
                    done_d  = (cfg_num_points == '0);
                    point_d = '0;
                    if (cfg_num_points != '0) begin
                        factor_d = cfg_factor_start;
                        state_d  = StReset;
                    end
                end
            end
            StReset: begin
                rst_cnt_d = rst_cnt_q + RstW'(1);
                if (ctrl_abort) begin
                    state_d = StDrain;
                end else if (rst_cnt_q == RstLast) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (ctrl_abort || stop) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                // The first drain cycle never exits, so data_en is low for at least one cycle.
                if (drain_seen_q && (data_in_flight == '0)) begin
                    if (abort_q || ctrl_abort) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StReport;
                        capture = 1'b1;
                    end
                end
            end
            StReport: begin
                if (res_ready) begin
                    if (last_point) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else if (abort_q || ctrl_abort) begin
                        state_d = StIdle;
                    end else begin
                        state_d  = StReset;
                        point_d  = point_q + POINT_W'(1);
                        factor_d = factor_next;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge data_clk) begin
        if (data_reset) begin
            state_q        <= StIdle;
            rst_cnt_q      <= '0;
            point_q        <= '0;
            factor_q       <= '0;
            abort_q        <= 1'b0;
            done_q         <= 1'b0;
            drain_seen_q   <= 1'b0;
            step_q         <= '0;
            num_points_q   <= '0;
            max_blocks_q   <= '0;
            min_failed_q   <= '0;
            res_point      <= '0;
            res_factor     <= '0;
            res_finished   <= '0;
            res_bit_errors <= '0;
            res_failed     <= '0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            point_q      <= point_d;
            factor_q     <= factor_d;
            abort_q      <= abort_d;
            done_q       <= done_d;
            drain_seen_q <= (state_q == StDrain);
            if ((state_q == StIdle) && start_ok) begin
                step_q       <= cfg_factor_step;
                num_points_q <= cfg_num_points;
                max_blocks_q <= cfg_max_blocks;
                min_failed_q <= cfg_min_failed;
            end
            if (capture) begin
                res_point      <= point_q;
                res_factor     <= factor_q;
                res_finished   <= data_finished_blocks;
                res_bit_errors <= data_bit_errors;
                res_failed     <= data_failed_blocks;
            end
        end
    end

    assign data_en        = (state_q == StRun);
    assign data_sw_resetn = (state_q != StReset);
    assign data_factor    = factor_q;
    assign status_busy    = (state_q != StIdle);
    assign status_done    = done_q;
    assign status_point   = point_q;
    assign res_valid      = (state_q == StReport);

endmodule
